// File: rtl/wb_burst_master_if.sv
// Wishbone bus bundle between wb_burst_master (master) and the SDRAM controller port (slave).
interface wb_burst_master_if #(
    parameter int APP_AW = 26,
    parameter int dw     = 32
);
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [APP_AW-1:0] wb_addr_o;
    logic [dw-1:0]     wb_dat_o;
    logic [dw/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic              wb_ack_i;
    logic [dw-1:0]     wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone initiator issuing single and incrementing-burst reads/writes from a command plus data streams.
// Optional ack watchdog with abort: define WB_TIMEOUT_EN.
module wb_burst_master #(
    parameter int APP_AW  = 26,
    parameter int dw      = 32,
    parameter int bl      = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [bl-1:0]     cmd_len,
    input  logic              cmd_we,
    input  logic [dw-1:0]     wr_data,
    input  logic [dw/8-1:0]   wr_sel,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [dw-1:0]     rd_data,
    output logic              rd_valid,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              busy,
    wb_burst_master_if.master wb
);
    localparam int SW = dw / 8;

    typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_t;

    state_t            state_q, state_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic [bl-1:0]     rem_q, rem_d, load_q, load_d;
    logic              we_q, we_d, single_q, single_d;
    logic              hold_full_q, hold_full_d;
    logic [dw-1:0]     hold_dat_q, hold_dat_d;
    logic [SW-1:0]     hold_sel_q, hold_sel_d;
    logic [dw-1:0]     rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;

    logic              stb, ack, last_ack, wr_fire, abort, active;
    logic [bl-1:0]     len_eff;
    logic              cyc_o, we_o;
    logic [SW-1:0]     sel_o;
    logic [2:0]        cti_o;

    assign active   = (state_q == WR) || (state_q == RD);
    assign stb      = (state_q == RD) || ((state_q == WR) && hold_full_q);
    assign ack      = stb && wb.wb_ack_i;
    assign last_ack = ack && (rem_q == bl'(1));
    assign len_eff  = (cmd_len == '0) ? bl'(1) : cmd_len;
    assign wr_fire  = wr_valid && wr_ready;

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    // Counts only stalled strobe cycles; a write underrun (stb low) freezes it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !active || ack) tmo_q <= '0;
        else if (stb)                   tmo_q <= tmo_q + TW'(1);
    end

    assign abort = stb && !wb.wb_ack_i && (tmo_q == TW'(TIMEOUT - 1));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            addr_q      <= '0;
            rem_q       <= '0;
            load_q      <= '0;
            we_q        <= 1'b0;
            single_q    <= 1'b0;
            hold_full_q <= 1'b0;
            hold_dat_q  <= '0;
            hold_sel_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            load_q      <= load_d;
            we_q        <= we_d;
            single_q    <= single_d;
            hold_full_q <= hold_full_d;
            hold_dat_q  <= hold_dat_d;
            hold_sel_q  <= hold_sel_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        load_d      = load_q;
        we_d        = we_q;
        single_d    = single_q;
        hold_full_d = hold_full_q;
        hold_dat_d  = hold_dat_q;
        hold_sel_d  = hold_sel_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        err_d       = err_q;

        // A beat may load in the same cycle the previous one is acked.
        if (wr_fire) begin
            hold_full_d = 1'b1;
            hold_dat_d  = wr_data;
            hold_sel_d  = wr_sel;
        end else if (ack && (state_q == WR)) begin
            hold_full_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    we_d     = cmd_we;
                    single_d = (len_eff == bl'(1));
                    rem_d    = len_eff;
                    load_d   = len_eff - bl'(wr_fire);
                    state_d  = cmd_we ? WR : RD;
                end
            end
            WR, RD: begin
                if (wr_fire) load_d = load_q - bl'(1);
                if (ack) begin
                    addr_d = addr_q + APP_AW'(SW);
                    rem_d  = rem_q - bl'(1);
                end
                if ((state_q == RD) && ack) begin
                    rd_data_d  = wb.wb_dat_i;
                    rd_valid_d = 1'b1;
                end
                if (last_ack) begin
                    state_d = GAP;
                end else if (abort) begin
                    state_d     = GAP;
                    err_d       = 1'b1;
                    hold_full_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_o     = active;
        cmd_ready = (state_q == IDLE);
        busy      = active;
        cmd_done  = (state_q == GAP);
        cmd_err   = (state_q == GAP) && err_q;
        we_o      = active && we_q;
        sel_o     = '0;
        cti_o     = 3'b000;
        wr_ready  = 1'b0;
        if (active) begin
            sel_o = we_q ? hold_sel_q : '1;
            if (!single_q) cti_o = (rem_q == bl'(1)) ? 3'b111 : 3'b010;
        end
        if (state_q == IDLE)
            wr_ready = cmd_valid && cmd_we;
        else if (state_q == WR)
            wr_ready = (!hold_full_q || ack) && (load_q != '0);
    end

    assign wb.wb_cyc_o  = cyc_o;
    assign wb.wb_stb_o  = stb;
    assign wb.wb_we_o   = we_o;
    assign wb.wb_addr_o = addr_q;
    assign wb.wb_dat_o  = hold_dat_q;
    assign wb.wb_sel_o  = sel_o;
    assign wb.wb_cti_o  = cti_o;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: Wishbone slave model with programmable ack timing plus beat scoreboard.
module tb_wb_burst_master;
    localparam int AW = 26, DW = 32, BL = 9, TMO = 16;

    logic          clk = 1'b0, rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BL-1:0] cmd_len = '0;
    logic [31:0]   wr_data = '0, rd_data;
    logic [3:0]    wr_sel = '0;
    logic          wr_valid = 1'b0, wr_ready, rd_valid, cmd_done, cmd_err, busy;

    wb_burst_master_if #(.APP_AW(AW), .dw(DW)) wb ();

    wb_burst_master #(.APP_AW(AW), .dw(DW), .bl(BL), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_we(cmd_we), .wr_data(wr_data),
        .wr_sel(wr_sel), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy), .wb(wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    cti;
        logic          we;
        logic [31:0]   dat;
        logic [3:0]    sel;
    } beat_t;

    beat_t       sb_q[$];
    logic [31:0] rd_exp[$];
    int          ack_t[$];
    int checks = 0, failures = 0, cyc_n = 0;
    int ack_lat = 0, gap_beat = -1, gap_len = 0, wait_cnt = 0, beat_idx = 0, acks = 0;
    bit never_ack = 1'b0, prev_cyc = 1'b0;
    int n_cyc, n_gap, n_stb, n_done, n_err, n_rdv, n_rise;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] rd_pat(input logic [AW-1:0] a);
        return {6'd0, a} ^ 32'hA5C3_0F5A;
    endfunction

    // Slave model and bus monitor; all sampling on the falling edge.
    initial begin
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wb.wb_ack_i = 1'b0; wait_cnt = 0; beat_idx = 0; prev_cyc = 1'b0;
            end else begin
                if (wb.wb_cyc_o) n_cyc++;
                if (wb.wb_cyc_o && !wb.wb_stb_o) n_gap++;
                if (wb.wb_cyc_o && !prev_cyc) n_rise++;
                prev_cyc = wb.wb_cyc_o;
                if (wb.wb_cyc_o) begin
                    checks++;
                    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ready_while_busy got=%b want=0", cmd_ready); end
                end
                if (cmd_done) begin
                    n_done++;
                    if (cmd_err) n_err++;
                    checks++;
                    if (wb.wb_cyc_o !== 1'b0) begin failures++; $display("FAIL cyc_at_done got=%b want=0", wb.wb_cyc_o); end
                end
                if (cmd_err && !cmd_done) begin
                    checks++; failures++; $display("FAIL err_without_done got=1 want=0");
                end
                if (rd_valid) begin
                    n_rdv++;
                    checks++;
                    if (rd_exp.size() == 0) begin
                        failures++; $display("FAIL rd_unexpected got=%h want=none", rd_data);
                    end else begin
                        logic [31:0] e;
                        int ta;
                        e  = rd_exp.pop_front();
                        ta = (ack_t.size() > 0) ? ack_t.pop_front() : -10;
                        if (rd_data !== e) begin failures++; $display("FAIL rd_data got=%h want=%h", rd_data, e); end
                        checks++;
                        if (cyc_n - ta != 1) begin failures++; $display("FAIL rd_latency got=%0d want=1", cyc_n - ta); end
                    end
                end
                if (wb.wb_cyc_o && wb.wb_stb_o) begin
                    n_stb++;
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++; $display("FAIL stb_unexpected addr got=%h want=none", wb.wb_addr_o);
                    end else if (wb.wb_addr_o !== sb_q[0].addr || wb.wb_cti_o !== sb_q[0].cti || wb.wb_we_o !== sb_q[0].we) begin
                        failures++;
                        $display("FAIL beat_ctrl got addr=%h cti=%b we=%b want addr=%h cti=%b we=%b",
                                 wb.wb_addr_o, wb.wb_cti_o, wb.wb_we_o, sb_q[0].addr, sb_q[0].cti, sb_q[0].we);
                    end
                    if (!never_ack && wait_cnt >= ack_lat + ((beat_idx == gap_beat) ? gap_len : 0)) begin
                        wb.wb_ack_i = 1'b1;
                        wb.wb_dat_i = rd_pat(wb.wb_addr_o);
                        if (sb_q.size() > 0) begin
                            checks++;
                            if (wb.wb_sel_o !== sb_q[0].sel || (sb_q[0].we && wb.wb_dat_o !== sb_q[0].dat)) begin
                                failures++;
                                $display("FAIL beat_data got dat=%h sel=%h want dat=%h sel=%h",
                                         wb.wb_dat_o, wb.wb_sel_o, sb_q[0].dat, sb_q[0].sel);
                            end
                            if (!sb_q[0].we) ack_t.push_back(cyc_n);
                            void'(sb_q.pop_front());
                        end
                        beat_idx++; wait_cnt = 0; acks++;
                    end else begin
                        wb.wb_ack_i = 1'b0; wait_cnt++;
                    end
                end else begin
                    wb.wb_ack_i = 1'b0; wait_cnt = 0;
                    if (!wb.wb_cyc_o) beat_idx = 0;
                end
            end
        end
    end

    task automatic reset_stats();
        n_cyc = 0; n_gap = 0; n_stb = 0; n_done = 0; n_err = 0; n_rdv = 0; n_rise = 0; acks = 0;
        ack_lat = 0; gap_beat = -1; gap_len = 0; never_ack = 1'b0;
        sb_q.delete(); rd_exp.delete(); ack_t.delete();
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input int n, input bit we,
                            input logic [31:0] base, input logic [3:0] sel);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.addr = a + AW'(4 * i);
            b.cti  = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
            b.we   = we;
            b.dat  = we ? base + 32'(i) : 32'h0;
            b.sel  = we ? sel : 4'hF;
            sb_q.push_back(b);
            if (!we) rd_exp.push_back(rd_pat(b.addr));
        end
    endtask

    task automatic issue_cmd(input logic [AW-1:0] a, input int len, input bit we, output bit ok);
        int t = 0;
        ok = 1'b0;
        @(negedge clk);
        cmd_addr = a; cmd_len = BL'(len); cmd_we = we; cmd_valid = 1'b1;
        while (t < 200) begin
            #1;
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drive_wr(input int n, input logic [31:0] base, input logic [3:0] sel,
                            input int stall_after, input int stall_len, output bit ok);
        int i = 0, st = 0, t = 0;
        while (i < n && t < 500) begin
            @(negedge clk);
            t++;
            if (i == stall_after && st < stall_len) begin
                wr_valid = 1'b0; st++;
            end else begin
                wr_valid = 1'b1; wr_data = base + 32'(i); wr_sel = sel;
                #1;
                if (wr_ready) i++;
            end
        end
        ok = (i == n);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int max, output bit ok);
        int t = 0;
        while (n_done < n && t < max) begin @(negedge clk); t++; end
        ok = (n_done >= n);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || cmd_done !== 1'b0 || cmd_err !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got ready=%b busy=%b done=%b err=%b want 1 0 0 0", cmd_ready, busy, cmd_done, cmd_err);
        end
        checks++;
        if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_cti_o !== 3'b000 || wb.wb_sel_o !== 4'h0) begin
            failures++; $display("FAIL reset_bus got cyc=%b stb=%b cti=%b sel=%h want 0", wb.wb_cyc_o, wb.wb_stb_o, wb.wb_cti_o, wb.wb_sel_o);
        end
        checks++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
            failures++; $display("FAIL reset_stream got rd_valid=%b wr_ready=%b want 0 0", rd_valid, wr_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        bit ok1, ok2, ok3;
        reset_stats();
        ack_lat = 2;
        push_exp(26'h100, 1, 1'b1, 32'hDEAD_BEEF, 4'hF);
        fork
            issue_cmd(26'h100, 1, 1'b1, ok1);
            drive_wr(1, 32'hDEAD_BEEF, 4'hF, -1, 0, ok2);
        join
        wait_done(1, 100, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3)) begin failures++; $display("FAIL single_wr_handshake got=%b%b%b want=111", ok1, ok2, ok3); end
        checks++;
        if (n_done !== 1 || n_stb !== 3 || n_cyc !== 3 || sb_q.size() !== 0) begin
            failures++; $display("FAIL single_wr_counts got done=%0d stb=%0d cyc=%0d left=%0d want 1 3 3 0", n_done, n_stb, n_cyc, sb_q.size());
        end
    endtask

    task automatic test_write_burst();
        bit ok1, ok2, ok3;
        reset_stats();
        push_exp(26'h200, 4, 1'b1, 32'd1, 4'hF);
        fork
            issue_cmd(26'h200, 4, 1'b1, ok1);
            drive_wr(4, 32'd1, 4'hF, -1, 0, ok2);
        join
        wait_done(1, 100, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3)) begin failures++; $display("FAIL wr_burst_handshake got=%b%b%b want=111", ok1, ok2, ok3); end
        checks++;
        if (n_cyc !== 4 || n_gap !== 0 || n_stb !== 4 || n_done !== 1 || sb_q.size() !== 0) begin
            failures++; $display("FAIL wr_burst_counts got cyc=%0d gap=%0d stb=%0d done=%0d left=%0d want 4 0 4 1 0",
                                 n_cyc, n_gap, n_stb, n_done, sb_q.size());
        end
    endtask

    task automatic test_read_stall();
        bit ok1, ok2;
        reset_stats();
        gap_beat = 2; gap_len = 3;
        push_exp(26'h0, 8, 1'b0, 32'h0, 4'hF);
        issue_cmd(26'h0, 8, 1'b0, ok1);
        wait_done(1, 100, ok2);
        checks++;
        if (!(ok1 && ok2)) begin failures++; $display("FAIL rd_stall_handshake got=%b%b want=11", ok1, ok2); end
        checks++;
        if (n_rdv !== 8 || n_stb !== 11 || n_done !== 1 || rd_exp.size() !== 0) begin
            failures++; $display("FAIL rd_stall_counts got rdv=%0d stb=%0d done=%0d left=%0d want 8 11 1 0", n_rdv, n_stb, n_done, rd_exp.size());
        end
    endtask

    task automatic test_write_underrun();
        bit ok1, ok2, ok3;
        reset_stats();
        push_exp(26'h300, 3, 1'b1, 32'h1000_0000, 4'h5);
        fork
            issue_cmd(26'h300, 3, 1'b1, ok1);
            drive_wr(3, 32'h1000_0000, 4'h5, 1, 5, ok2);
        join
        wait_done(1, 100, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3)) begin failures++; $display("FAIL underrun_handshake got=%b%b%b want=111", ok1, ok2, ok3); end
        checks++;
        if (n_gap !== 5 || n_cyc !== 8 || n_rise !== 1 || sb_q.size() !== 0) begin
            failures++; $display("FAIL underrun_counts got gap=%0d cyc=%0d rise=%0d left=%0d want 5 8 1 0", n_gap, n_cyc, n_rise, sb_q.size());
        end
    endtask

    task automatic test_len_zero();
        bit ok1, ok2;
        reset_stats();
        push_exp(26'h40, 1, 1'b0, 32'h0, 4'hF);
        issue_cmd(26'h40, 0, 1'b0, ok1);
        wait_done(1, 50, ok2);
        checks++;
        if (!(ok1 && ok2) || n_rdv !== 1 || n_stb !== 1 || sb_q.size() !== 0) begin
            failures++; $display("FAIL len_zero got ok=%b%b rdv=%0d stb=%0d want 11 1 1", ok1, ok2, n_rdv, n_stb);
        end
    endtask

    task automatic test_wrap();
        bit ok1, ok2;
        logic [AW-1:0] top;
        reset_stats();
        top = {AW{1'b1}} - AW'(7);
        push_exp(top, 4, 1'b0, 32'h0, 4'hF);
        checks++;
        if (sb_q[2].addr !== 26'h0 || sb_q[3].addr !== 26'h4) begin
            failures++; $display("FAIL wrap_model got=%h,%h want=0,4", sb_q[2].addr, sb_q[3].addr);
        end
        issue_cmd(top, 4, 1'b0, ok1);
        wait_done(1, 50, ok2);
        checks++;
        if (!(ok1 && ok2) || n_rdv !== 4 || sb_q.size() !== 0 || wb.wb_addr_o !== 26'h8) begin
            failures++; $display("FAIL wrap got ok=%b%b rdv=%0d addr=%h want 11 4 0000008", ok1, ok2, n_rdv, wb.wb_addr_o);
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        reset_stats();
        push_exp(26'h500, 2, 1'b0, 32'h0, 4'hF);
        push_exp(26'h600, 2, 1'b0, 32'h0, 4'hF);
        issue_cmd(26'h500, 2, 1'b0, ok1);
        issue_cmd(26'h600, 2, 1'b0, ok2);
        wait_done(2, 100, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3) || n_done !== 2 || n_rise !== 2 || n_rdv !== 4 || rd_exp.size() !== 0) begin
            failures++; $display("FAIL back_to_back got ok=%b%b%b done=%0d rise=%0d rdv=%0d want 111 2 2 4", ok1, ok2, ok3, n_done, n_rise, n_rdv);
        end
    endtask

    task automatic test_reset_mid();
        bit ok1, hit = 1'b0;
        int t = 0;
        reset_stats();
        push_exp(26'h800, 8, 1'b0, 32'h0, 4'hF);
        issue_cmd(26'h800, 8, 1'b0, ok1);
        while (!hit && t < 100) begin
            @(negedge clk); #2;
            if (wb.wb_ack_i === 1'b1 && acks == 2) hit = 1'b1;
            t++;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (!(ok1 && hit)) begin failures++; $display("FAIL rst_mid_reach got=%b%b want=11", ok1, hit); end
        checks++;
        if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_state got cyc=%b stb=%b ready=%b busy=%b rdv=%b want 0 0 1 0 0",
                                 wb.wb_cyc_o, wb.wb_stb_o, cmd_ready, busy, rd_valid);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (n_done !== 0 || n_rdv !== 1 || wb.wb_cyc_o !== 1'b0) begin
            failures++; $display("FAIL rst_mid_after got done=%0d rdv=%0d cyc=%b want 0 1 0", n_done, n_rdv, wb.wb_cyc_o);
        end
        reset_stats();
    endtask

    task automatic test_timeout();
        bit ok1, ok2;
        reset_stats();
        never_ack = 1'b1;
        push_exp(26'h900, 2, 1'b0, 32'h0, 4'hF);
        issue_cmd(26'h900, 2, 1'b0, ok1);
`ifdef WB_TIMEOUT_EN
        wait_done(1, 100, ok2);
        checks++;
        if (!(ok1 && ok2) || n_stb !== TMO || n_err !== 1 || n_rdv !== 0 || wb.wb_cyc_o !== 1'b0) begin
            failures++; $display("FAIL timeout_abort got ok=%b%b stb=%0d err=%0d rdv=%0d want 11 %0d 1 0", ok1, ok2, n_stb, n_err, n_rdv, TMO);
        end
`else
        repeat (40) @(negedge clk);
        ok2 = 1'b1;
        checks++;
        if (!(ok1 && ok2) || wb.wb_cyc_o !== 1'b1 || wb.wb_stb_o !== 1'b1 || n_done !== 0 || cmd_err !== 1'b0) begin
            failures++; $display("FAIL timeout_off got ok=%b cyc=%b stb=%b done=%0d err=%b want 1 1 1 0 0", ok1, wb.wb_cyc_o, wb.wb_stb_o, n_done, cmd_err);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        reset_stats();
    endtask

    initial begin
        reset_stats();
        test_reset();
        test_single_write();
        test_write_burst();
        test_read_stall();
        test_write_underrun();
        test_len_zero();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone initiator that issues single and incrementing-burst read/write cycles into the SDRAM controller's Wishbone slave port.
- Accepts a command (address, length, direction) plus a write-data stream, and returns a read-data stream.
- Sits between DMA/test-traffic logic and the controller.
- Used as the bring-up traffic source and as the bus master in system benches.

Parameters:
APP_AW, 26, byte address width
dw, 32, Wishbone data width (bits)
bl, 9, burst length field width (words)
TIMEOUT, 255, ack watchdog limit in cycles (used only with WB_TIMEOUT_EN)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_addr  in  APP_AW  start byte address, dw/8-aligned
cmd_len  in  bl  beat count; 0 is treated as 1
cmd_we  in  1  1 = write, 0 = read
wr_data  in  dw  write beat data
wr_sel  in  dw/8  write byte enables
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat taken when high with wr_valid
rd_data  out  dw  read beat data
rd_valid  out  1  one-cycle pulse per read beat; no backpressure
cmd_done  out  1  one-cycle pulse after last ack of a command
cmd_err  out  1  one-cycle pulse with cmd_done on timeout abort (0 when feature off)
busy  out  1  high from command accept until cmd_done
wb_cyc_o  out  1  WB cycle
wb_stb_o  out  1  WB strobe
wb_we_o  out  1  WB write enable
wb_addr_o  out  APP_AW  WB byte address
wb_dat_o  out  dw  WB write data
wb_sel_o  out  dw/8  WB byte select (all ones for reads)
wb_cti_o  out  3  WB cycle type
wb_ack_i  in  1  WB acknowledge
wb_dat_i  in  dw  WB read data

Behaviour:
- Clocking: single clock wb_clk_i. wb_rst_i is synchronous and active-high; all state updates on the rising edge of wb_clk_i.
- Reset values: all outputs 0 except cmd_ready=1; state IDLE.
- State machine: IDLE, WR, RD, GAP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, remaining count = max(cmd_len,1), and we.
  - Go to WR if we=1, else RD. wb_cyc_o rises the next cycle.
- WR:
  - 1-entry holding register feeds wb_dat_o/wb_sel_o.
  - wr_ready = (hold empty OR wb_ack_i) AND beats still to load.
  - wb_stb_o = hold full.
  - A new beat may load in the same cycle as the ack of the previous one, giving zero-bubble bursts.
- RD:
  - wb_stb_o=1 until the last ack.
  - On each ack, rd_data <= wb_dat_i and rd_valid pulses high the following cycle (1-cycle latency).
- Each ack:
  - wb_addr_o += dw/8; address wraps modulo 2^APP_AW.
  - Remaining count decrements.
- wb_cti_o:
  - 3'b000 when the command length is 1.
  - Otherwise 3'b010 on all beats except the last, which is 3'b111.
  - Updated combinationally from the remaining count.
- wb_cyc_o stays high continuously for the whole command, including write stalls where wr_valid=0 (stb low, cyc high).
- Last ack → GAP:
  - wb_cyc_o and wb_stb_o drop.
  - cmd_done pulses; busy falls.
  - One idle cycle, then IDLE. Back-to-back commands therefore have ≥1 cycle with cyc low.
- Signals are held stable while stb=1 and ack=0: addr, dat_o, sel_o, we_o, cti_o.
- wb_ack_i while stb=0 is ignored.
- cmd_valid while busy: not accepted (cmd_ready=0).
- Reset mid-burst: cyc/stb drop the next edge; holding register is discarded; no cmd_done is produced.
- wb_ack_i seen on the reset cycle is ignored.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - A counter counts cycles with stb=1 and ack=0; it clears on ack.
  - When it reaches TIMEOUT, the cycle is aborted: cyc/stb drop, then GAP, with cmd_done and cmd_err pulsing together.
  - Remaining beats are dropped. For writes, wr_ready stays 0 for the rest of the command.
- Undefined: no counter is built, cmd_err is tied to 0, and the master waits indefinitely.

Test Plan:
- Single write: cmd addr=0x100, len=1, we=1, wr_data=0xDEADBEEF, wr_sel=0xF, slave acks 2 cycles after stb → one stb with cti=000, addr=0x100; cmd_done pulses once; cyc low ≥1 cycle after.
- Write burst: addr=0x200, len=4, data 1..4 streamed continuously, ack every cycle → addrs 0x200/204/208/20C, cti 010,010,010,111; no stb gaps; cyc high for exactly 4 cycles.
- Read burst with stalls: addr=0x0, len=8, slave inserts a 3-cycle ack gap on beat 3 → addr/cti held stable during the gap; 8 rd_valid pulses, each 1 cycle after its ack, with data in order.
- Write underrun: len=3, wr_valid low for 5 cycles after beat 1 → stb low and cyc high during the stall; burst completes with correct data.
- Address wrap and reset: addr=2^26-8, len=4 → addrs wrap to 0x0 and 0x4; separately, assert wb_rst_i on beat 2 of a len=8 read → cyc=0 next cycle, no cmd_done, cmd_ready=1.
- With WB_TIMEOUT_EN and TIMEOUT=16: slave never acks a read → after 16 stall cycles cyc drops and cmd_done+cmd_err pulse together; without the macro, cyc stays high.
